// File: rtl/output_drain_pkg.sv
// Shared types and arithmetic helpers for the accumulator post-processing stages.
// round_sat works on a sign-extended 64-bit value so any W up to 63 bits can reuse it.
package output_drain_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } drain_state_t;

    localparam int unsigned RS_WIDTH = 64;

    // Round half toward +inf on the right shift, then clamp to a signed out_w range.
    function automatic logic signed [RS_WIDTH-1:0] round_sat(
        input logic signed [RS_WIDTH-1:0] x,
        input int unsigned                shift,
        input int unsigned                out_w
    );
        logic signed [RS_WIDTH-1:0] y;
        logic signed [RS_WIDTH-1:0] hi;
        logic signed [RS_WIDTH-1:0] lo;
        if (shift > 0) begin
            y = (x + (64'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            y = x;
        end
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (y > hi) begin
            return hi;
        end else if (y < lo) begin
            return lo;
        end
        return y;
    endfunction

endpackage

// File: rtl/output_drain_fifo.sv
// Synchronous FIFO of {last, data} entries; head entry is read straight from storage
// flops so m_data/m_last never see combinational input paths.
module output_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        pop_ok  = pop_i && (count_q != '0);
        // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
        push_ok = push_i && ((count_q < CW'(DEPTH)) || pop_ok);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/output_drain.sv
// Drains accumulated partial sums from the accumulator BRAM, applies ReLU/round/saturate,
// streams the results out and optionally zeroes each consumed word for the next tile.
module output_drain
    import output_drain_pkg::*;
#(
    parameter int unsigned I_WIDTH         = 8,
    parameter int unsigned F_WIDTH         = 8,
    parameter int unsigned BRAM_ADDR_WIDTH = 11,
    parameter int unsigned OUT_WIDTH       = 8,
    parameter int unsigned FRAC_SHIFT      = 8,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [BRAM_ADDR_WIDTH-1:0]   base_addr_i,
    input  logic [BRAM_ADDR_WIDTH:0]     count_i,
    input  logic                         relu_en_i,
    input  logic                         clear_en_i,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_addr_o,
    input  logic [I_WIDTH+F_WIDTH-1:0]   bram_data_i,
    output logic                         bram_clr_en_o,
    output logic [BRAM_ADDR_WIDTH-1:0]   bram_clr_addr_o,
    output logic [OUT_WIDTH-1:0]         m_data_o,
    output logic                         m_valid_o,
    input  logic                         m_ready_i,
    output logic                         m_last_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int unsigned W  = I_WIDTH + F_WIDTH;
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    drain_state_t               state_q, state_d;
    logic [BRAM_ADDR_WIDTH-1:0] base_q;
    logic [BRAM_ADDR_WIDTH-1:0] prev_addr_q;
    logic [BRAM_ADDR_WIDTH-1:0] rd_addr;
    logic [BRAM_ADDR_WIDTH:0]   count_q;
    logic [BRAM_ADDR_WIDTH:0]   issued_q;
    logic [BRAM_ADDR_WIDTH:0]   returned_q;
    logic                       relu_q;
    logic                       clr_q;
    logic                       inflight_q;
    logic                       issue;
    logic                       push;
    logic                       pop;
    logic                       accept;
    logic [CW-1:0]              fifo_count;
    logic [CW-1:0]              occupancy;
    logic [W-1:0]               x_relu;
    logic [OUT_WIDTH:0]         push_entry;
    logic [OUT_WIDTH:0]         head_entry;

    always_comb begin
        accept    = (state_q == IDLE) && start_i;
        // Count the outstanding read so its data always has a free FIFO slot on return.
        occupancy = fifo_count + CW'(inflight_q);
        issue     = (state_q == RUN) && (issued_q < count_q) && (occupancy < CW'(FIFO_DEPTH));
        rd_addr   = base_q + issued_q[BRAM_ADDR_WIDTH-1:0];
        push      = inflight_q;
        pop       = m_valid_o && m_ready_i;
        x_relu    = (relu_q && bram_data_i[W-1]) ? '0 : bram_data_i;
        push_entry = {
            (returned_q == count_q - 1'b1),
            OUT_WIDTH'(round_sat({{(RS_WIDTH - W){x_relu[W-1]}}, x_relu}, FRAC_SHIFT, OUT_WIDTH))
        };
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (count_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (pop && m_last_o) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            base_q      <= '0;
            count_q     <= '0;
            relu_q      <= 1'b0;
            clr_q       <= 1'b0;
            issued_q    <= '0;
            returned_q  <= '0;
            inflight_q  <= 1'b0;
            prev_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            inflight_q <= issue;
            if (accept) begin
                base_q     <= base_addr_i;
                count_q    <= count_i;
                relu_q     <= relu_en_i;
                clr_q      <= clear_en_i;
                issued_q   <= '0;
                returned_q <= '0;
            end else begin
                if (issue) begin
                    issued_q    <= issued_q + 1'b1;
                    prev_addr_q <= rd_addr;
                end
                if (push) begin
                    returned_q <= returned_q + 1'b1;
                end
            end
        end
    end

    output_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (OUT_WIDTH + 1)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (push_entry),
        .pop_i   (pop),
        .data_o  (head_entry),
        .count_o (fifo_count)
    );

    assign bram_addr_o     = rd_addr;
    assign bram_clr_en_o   = inflight_q && clr_q;
    assign bram_clr_addr_o = prev_addr_q;
    assign m_valid_o       = (fifo_count != '0);
    assign m_data_o        = head_entry[OUT_WIDTH-1:0];
    assign m_last_o        = head_entry[OUT_WIDTH];
    assign busy_o          = (state_q == RUN);
    assign done_o          = (state_q == DONE);

endmodule

// File: tb/tb_output_drain.sv
// Scenario bench for output_drain with a behavioural accumulator BRAM and a stream scoreboard.
module tb_output_drain;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [10:0] base_addr_i = '0;
    logic [11:0] count_i = '0;
    logic        relu_en_i = 1'b0;
    logic        clear_en_i = 1'b0;
    logic [10:0] bram_addr_o;
    logic [15:0] bram_data_i = '0;
    logic        bram_clr_en_o;
    logic [10:0] bram_clr_addr_o;
    logic [7:0]  m_data_o;
    logic        m_valid_o;
    logic        m_ready_i = 1'b1;
    logic        m_last_o;
    logic        busy_o;
    logic        done_o;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;
    int pop_cnt = 0;
    int done_cnt = 0;
    int done_cyc = 0;
    int valid_cnt = 0;

    logic [15:0] mem [2048];
    logic        ld_en = 1'b0;
    logic [10:0] ld_addr = '0;
    logic [15:0] ld_data = '0;

    logic [8:0]  sb [$];
    int          pop_cyc [$];
    int          clr_log [$];
    int          clr_cyc [$];

    output_drain #(
        .I_WIDTH         (8),
        .F_WIDTH         (8),
        .BRAM_ADDR_WIDTH (11),
        .OUT_WIDTH       (8),
        .FRAC_SHIFT      (8),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .base_addr_i     (base_addr_i),
        .count_i         (count_i),
        .relu_en_i       (relu_en_i),
        .clear_en_i      (clear_en_i),
        .bram_addr_o     (bram_addr_o),
        .bram_data_i     (bram_data_i),
        .bram_clr_en_o   (bram_clr_en_o),
        .bram_clr_addr_o (bram_clr_addr_o),
        .m_data_o        (m_data_o),
        .m_valid_o       (m_valid_o),
        .m_ready_i       (m_ready_i),
        .m_last_o        (m_last_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        cyc <= cyc + 1;
        bram_data_i <= mem[bram_addr_o];
        if (ld_en) mem[ld_addr] <= ld_data;
        else if (bram_clr_en_o) mem[bram_clr_addr_o] <= '0;
    end

    // Stream scoreboard and event logging, sampled mid-cycle.
    always @(negedge clk_i) begin
        logic [8:0] exp;
        if (!rst_i) begin
            if (m_valid_o && m_ready_i) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL stream_extra got data=%0d last=%0b expected no word", $signed(m_data_o), m_last_o);
                end else begin
                    exp = sb.pop_front();
                    if ({m_last_o, m_data_o} !== exp) begin
                        errors++;
                        $display("FAIL stream_word got data=%0d last=%0b expected data=%0d last=%0b",
                                 $signed(m_data_o), m_last_o, $signed(exp[7:0]), exp[8]);
                    end
                end
                pop_cnt++;
                pop_cyc.push_back(cyc);
            end
            if (bram_clr_en_o) begin
                clr_log.push_back(int'(bram_clr_addr_o));
                clr_cyc.push_back(cyc);
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_valid_o) valid_cnt++;
        end
    end

    function automatic logic [7:0] exp_word(input logic [15:0] w, input bit relu);
        int x;
        int y;
        x = int'($signed(w));
        if (relu && x < 0) x = 0;
        y = (x + 128) >>> 8;
        if (y > 127) y = 127;
        if (y < -128) y = -128;
        return y[7:0];
    endfunction

    task automatic load_word(input int a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_addr = a[10:0];
        ld_data = d;
        @(posedge clk_i);
        #1 ld_en = 1'b0;
    endtask

    task automatic start_drain(input int base, input int cnt, input bit relu, input bit clr);
        for (int i = 0; i < cnt; i++) begin
            int a;
            a = (base + i) % 2048;
            sb.push_back({(i == cnt - 1), exp_word(mem[a], relu)});
        end
        pop_cyc.delete();
        clr_log.delete();
        clr_cyc.delete();
        base_addr_i = base[10:0];
        count_i = cnt[11:0];
        relu_en_i = relu;
        clear_en_i = clr;
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            @(posedge clk_i);
            n++;
        end
        timed_out = (done_cnt == d0);
        repeat (3) @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        checks++;
        if ({bram_addr_o, bram_clr_en_o, bram_clr_addr_o, m_data_o, m_valid_o, m_last_o, busy_o, done_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got addr=%0d clr=%0b clra=%0d data=%0d v=%0b l=%0b busy=%0b done=%0b expected all 0",
                     bram_addr_o, bram_clr_en_o, bram_clr_addr_o, m_data_o, m_valid_o, m_last_o, busy_o, done_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic test_basic(input bit relu);
        bit to;
        int d0;
        d0 = done_cnt;
        m_ready_i = 1'b1;
        start_drain(10, 4, relu, 1'b0);
        checks++;
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy got %0b expected 1", busy_o);
        end
        wait_done(50, to);
        checks++;
        if (to || sb.size() != 0 || pop_cyc.size() != 4) begin
            errors++;
            $display("FAIL basic_complete timeout=%0b left=%0d pops=%0d expected 0/0/4", to, sb.size(), pop_cyc.size());
        end else begin
            checks++;
            if (pop_cyc[0] != start_cyc + 2 || pop_cyc[3] != pop_cyc[0] + 3) begin
                errors++;
                $display("FAIL basic_timing got first=%0d last=%0d expected first=%0d last=%0d",
                         pop_cyc[0], pop_cyc[3], start_cyc + 2, start_cyc + 5);
            end
            checks++;
            if (done_cyc != pop_cyc[3] + 1 || done_cnt != d0 + 1) begin
                errors++;
                $display("FAIL basic_done got cyc=%0d pulses=%0d expected cyc=%0d pulses=1",
                         done_cyc, done_cnt - d0, pop_cyc[3] + 1);
            end
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle_busy got %0b expected 0", busy_o);
        end
    endtask

    task automatic test_clear_wrap;
        bit to;
        int exp_addr [4];
        exp_addr = '{2046, 2047, 0, 1};
        for (int i = 0; i < 4; i++) load_word(exp_addr[i], 16'($urandom_range(1, 65535)));
        start_drain(2046, 4, 1'b0, 1'b1);
        wait_done(50, to);
        checks++;
        if (to || sb.size() != 0 || clr_log.size() != 4) begin
            errors++;
            $display("FAIL wrap_complete timeout=%0b left=%0d clears=%0d expected 0/0/4", to, sb.size(), clr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (clr_log[i] != exp_addr[i] || clr_cyc[i] != start_cyc + 1 + i || mem[exp_addr[i]] !== 16'h0) begin
                    errors++;
                    $display("FAIL wrap_clear[%0d] got addr=%0d cyc=%0d mem=%h expected addr=%0d cyc=%0d mem=0000",
                             i, clr_log[i], clr_cyc[i], mem[exp_addr[i]], exp_addr[i], start_cyc + 1 + i);
                end
            end
        end
    endtask

    task automatic test_backpressure;
        bit to;
        bit have;
        logic [8:0] held;
        int p0;
        for (int i = 0; i < 8; i++) load_word(100 + i, 16'($urandom_range(1, 65535)));
        p0 = pop_cnt;
        have = 1'b0;
        held = '0;
        m_ready_i = 1'b0;
        start_drain(100, 8, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (m_valid_o) begin
                if (!have) begin
                    have = 1'b1;
                    held = {m_last_o, m_data_o};
                end else begin
                    checks++;
                    if ({m_last_o, m_data_o} !== held) begin
                        errors++;
                        $display("FAIL stall_hold got %h expected %h", {m_last_o, m_data_o}, held);
                    end
                end
            end
        end
        checks++;
        if (clr_log.size() != 4 || !have) begin
            errors++;
            $display("FAIL stall_reads got %0d reads valid=%0b expected 4 reads valid=1", clr_log.size(), have);
        end
        @(posedge clk_i);
        #1 m_ready_i = 1'b1;
        wait_done(80, to);
        checks++;
        if (to || sb.size() != 0 || pop_cnt - p0 != 8 || clr_log.size() != 8) begin
            errors++;
            $display("FAIL stall_drain timeout=%0b left=%0d pops=%0d clears=%0d expected 0/0/8/8",
                     to, sb.size(), pop_cnt - p0, clr_log.size());
        end
    endtask

    task automatic test_zero_count;
        bit to;
        int d0;
        int v0;
        d0 = done_cnt;
        v0 = valid_cnt;
        start_drain(50, 0, 1'b0, 1'b1);
        wait_done(5, to);
        checks++;
        if (to || done_cnt != d0 + 1 || valid_cnt != v0 || clr_log.size() != 0 || done_cyc > start_cyc + 1) begin
            errors++;
            $display("FAIL zero_count timeout=%0b pulses=%0d valid_cycles=%0d clears=%0d done_lag=%0d expected 0/1/0/0/<=1",
                     to, done_cnt - d0, valid_cnt - v0, clr_log.size(), done_cyc - start_cyc);
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int p0;
        int n;
        int nclr;
        logic [15:0] orig [6];
        for (int i = 0; i < 6; i++) begin
            orig[i] = 16'($urandom_range(1, 65535));
            load_word(200 + i, orig[i]);
        end
        p0 = pop_cnt;
        m_ready_i = 1'b1;
        start_drain(200, 6, 1'b0, 1'b1);
        n = 0;
        while (pop_cnt < p0 + 3 && n < 50) begin
            @(posedge clk_i);
            n++;
        end
        checks++;
        if (pop_cnt < p0 + 3) begin
            errors++;
            $display("FAIL midrst_wait got %0d pops expected 3", pop_cnt - p0);
        end
        #1 rst_i = 1'b1;
        #1;
        checks++;
        if ({bram_addr_o, bram_clr_en_o, bram_clr_addr_o, m_data_o, m_valid_o, m_last_o, busy_o, done_o} !== '0) begin
            errors++;
            $display("FAIL midrst_outputs got addr=%0d clr=%0b data=%0d v=%0b busy=%0b expected all 0",
                     bram_addr_o, bram_clr_en_o, m_data_o, m_valid_o, busy_o);
        end
        repeat (2) @(posedge clk_i);
        #1;
        sb.delete();
        nclr = clr_log.size();
        checks++;
        if (nclr < 3 || nclr > 6) begin
            errors++;
            $display("FAIL midrst_clear_count got %0d expected 3..6", nclr);
        end
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i < nclr) begin
                if (clr_log[i] != 200 + i || mem[200 + i] !== 16'h0) begin
                    errors++;
                    $display("FAIL midrst_cleared[%0d] got addr=%0d mem=%h expected addr=%0d mem=0000", i, clr_log[i], mem[200 + i], 200 + i);
                end
            end else if (mem[200 + i] !== orig[i]) begin
                errors++;
                $display("FAIL midrst_untouched[%0d] got %h expected %h", i, mem[200 + i], orig[i]);
            end
        end
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        load_word(300, 16'h0180);
        load_word(301, 16'h8000);
        load_word(302, 16'h00FF);
        start_drain(300, 3, 1'b0, 1'b0);
        wait_done(50, to);
        checks++;
        if (to || sb.size() != 0) begin
            errors++;
            $display("FAIL midrst_restart timeout=%0b left=%0d expected 0/0", to, sb.size());
        end
    endtask

    task automatic test_full_wrap;
        bit to;
        int nz;
        for (int i = 0; i < 2048; i++) load_word(i, 16'($urandom_range(1, 65535)));
        start_drain(5, 2048, 1'b1, 1'b1);
        wait_done(2200, to);
        nz = 0;
        for (int i = 0; i < 2048; i++) if (mem[i] !== 16'h0) nz++;
        checks++;
        if (to || sb.size() != 0 || clr_log.size() != 2048 || nz != 0) begin
            errors++;
            $display("FAIL full_wrap timeout=%0b left=%0d clears=%0d nonzero=%0d expected 0/0/2048/0",
                     to, sb.size(), clr_log.size(), nz);
        end
    endtask

    initial begin
        test_reset();
        load_word(10, 16'h0180);
        load_word(11, 16'h7FFF);
        load_word(12, 16'hFE80);
        load_word(13, 16'h8000);
        test_basic(1'b0);
        test_basic(1'b1);
        test_clear_wrap();
        test_backpressure();
        test_zero_count();
        test_reset_mid();
        test_full_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
